// File: rtl/round_judge_pkg.sv
// Shared types and constants for the round judging stage.
package round_judge_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_OPEN,
      S_ARMED,
      S_JUDGED,
      S_OVER
   } state_t;

   localparam int KEY_W   = 4;
   localparam int SCORE_W = 8;
   localparam int LIVES_W = 2;
   localparam int RT_W    = 4;

   localparam int LIVES_INIT_DEF     = 3;
   localparam int RT_START_DEF       = 12;
   localparam int RT_MIN_DEF         = 4;
   localparam int HITS_PER_LEVEL_DEF = 8;

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer with registered rising-edge strobes per bit and a
// registered falling-edge strobe for bit 0 (the window lane).
module key_sync_edge #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] din,
   output logic [W-1:0] rise,
   output logic         fall0
);

   logic [W-1:0] meta;
   logic [W-1:0] sync;
   logic [W-1:0] prev;

   // Synchronize, keep one cycle of history, and register the edge strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta  <= '0;
         sync  <= '0;
         prev  <= '0;
         rise  <= '0;
         fall0 <= 1'b0;
      end else begin
         // NOTE: non-blocking so each flop takes its neighbour's pre-edge value; blocking would collapse the chain into one stage.
         meta  <= din;
         sync  <= meta;
         prev  <= sync;
         rise  <= sync & ~prev;
         fall0 <= ~sync[0] & prev[0];
      end
   end

endmodule

// File: rtl/round_judge.sv
// Round judging stage: judges one press per round window, tracks score,
// lives and difficulty (roundTime), and flags game over.
module round_judge
   import round_judge_pkg::*;
#(
   parameter int LIVES_INIT     = LIVES_INIT_DEF,
   parameter int RT_START       = RT_START_DEF,
   parameter int RT_MIN         = RT_MIN_DEF,
   parameter int HITS_PER_LEVEL = HITS_PER_LEVEL_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               gameState,
   input  logic               window,
   input  logic [KEY_W-1:0]   target,
   input  logic [KEY_W-1:0]   keys,
   output logic [RT_W-1:0]    roundTime,
   output logic               hit,
   output logic               miss,
   output logic [SCORE_W-1:0] score,
   output logic [LIVES_W-1:0] lives,
   output logic               gameOver
);

   localparam logic [LIVES_W-1:0] LIVES_INIT_V = LIVES_W'(LIVES_INIT);
   localparam logic [RT_W-1:0]    RT_START_V   = RT_W'(RT_START);
   localparam logic [RT_W-1:0]    RT_MIN_V     = RT_W'(RT_MIN);
   localparam logic [SCORE_W-1:0] LEVEL_MASK   = SCORE_W'(HITS_PER_LEVEL - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX    = '1;

   state_t             state;
   logic               gs_prev;
   logic [KEY_W-1:0]   tgt_q;
   logic [KEY_W:0]     rise;
   logic               win_fall;
   logic               win_rise;
   logic [KEY_W-1:0]   key_edge;
   logic [SCORE_W-1:0] score_inc;
   logic               level_up;
   logic               last_life;

   key_sync_edge #(
      .W (KEY_W + 1)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   ({keys, window}),
      .rise  (rise),
      .fall0 (win_fall)
   );

   assign win_rise  = rise[0];
   assign key_edge  = rise[KEY_W:1];
   assign score_inc = score + SCORE_W'(1);
   assign level_up  = (score_inc & LEVEL_MASK) == '0;
   assign last_life = (lives == LIVES_W'(1));

   // Round FSM with registered verdict pulses, score, lives and difficulty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         gs_prev   <= 1'b0;
         tgt_q     <= '0;
         score     <= '0;
         lives     <= LIVES_INIT_V;
         roundTime <= RT_START_V;
         hit       <= 1'b0;
         miss      <= 1'b0;
         gameOver  <= 1'b0;
      end else begin
         hit     <= 1'b0;
         miss    <= 1'b0;
         gs_prev <= gameState;
         if (!gameState && state != S_OVER) begin
            // Abort: counters hold until the next start.
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (gameState && !gs_prev) begin
                     score     <= '0;
                     lives     <= LIVES_INIT_V;
                     roundTime <= RT_START_V;
                     gameOver  <= 1'b0;
                     state     <= S_WAIT_OPEN;
                  end
               end
               S_WAIT_OPEN: begin
                  if (win_rise) begin
                     tgt_q <= target;
                     state <= S_ARMED;
                  end
               end
               S_ARMED: begin
                  if (key_edge != '0) begin
                     // A press that coincides with the window fall has already
                     // seen the close, so skip JUDGED's wait for it.
                     state <= win_fall ? S_WAIT_OPEN : S_JUDGED;
                     if (key_edge == tgt_q) begin
                        hit <= 1'b1;
                        if (score != SCORE_MAX) begin
                           score <= score_inc;
                           if (level_up && roundTime > RT_MIN_V)
                              roundTime <= roundTime - RT_W'(1);
                        end
                     end else begin
                        miss  <= 1'b1;
                        lives <= lives - LIVES_W'(1);
                        if (last_life) begin
                           gameOver <= 1'b1;
                           state    <= S_OVER;
                        end
                     end
                  end else if (win_fall) begin
                     miss  <= 1'b1;
                     lives <= lives - LIVES_W'(1);
                     if (last_life) begin
                        gameOver <= 1'b1;
                        state    <= S_OVER;
                     end else begin
                        state <= S_WAIT_OPEN;
                     end
                  end
               end
               S_JUDGED: begin
                  if (win_fall) state <= S_WAIT_OPEN;
               end
               S_OVER: begin
                  if (!gameState) state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_round_judge.sv
// Self-checking bench for round_judge: randomized rounds against a
// rule-level model of score, lives, roundTime and game over.
module tb_round_judge;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       gameState;
   logic       window;
   logic [3:0] target;
   logic [3:0] keys;
   logic [3:0] roundTime;
   logic       hit;
   logic       miss;
   logic [7:0] score;
   logic [1:0] lives;
   logic       gameOver;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   int m_score;
   int m_lives;
   int m_rt;
   bit m_over;

   // Pulse observation over a stretch of cycles
   int r_cyc;
   int r_hits;
   int r_misses;
   int r_both;
   int r_first;

   round_judge dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .gameState (gameState),
      .window    (window),
      .target    (target),
      .keys      (keys),
      .roundTime (roundTime),
      .hit       (hit),
      .miss      (miss),
      .score     (score),
      .lives     (lives),
      .gameOver  (gameOver)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void model_start();
      m_score = 0;
      m_lives = 3;
      m_rt    = 12;
      m_over  = 1'b0;
   endfunction

   function automatic void model_hit();
      if (m_score < 255) begin
         m_score = m_score + 1;
         if (m_score % 8 == 0 && m_rt > 4) m_rt = m_rt - 1;
      end
   endfunction

   function automatic void model_miss();
      m_lives = m_lives - 1;
      if (m_lives == 0) m_over = 1'b1;
   endfunction

   function automatic logic [3:0] onehot(input int idx);
      logic [3:0] v;
      v = 4'b0001 << idx;
      return v;
   endfunction

   task automatic clear_obs();
      r_cyc    = 0;
      r_hits   = 0;
      r_misses = 0;
      r_both   = 0;
      r_first  = -1;
   endtask

   // Advance to the next falling edge and record any verdict pulses.
   task automatic step();
      @(negedge clk);
      r_cyc = r_cyc + 1;
      if (hit && miss) r_both = r_both + 1;
      if (hit) r_hits = r_hits + 1;
      if (miss) r_misses = r_misses + 1;
      if ((hit || miss) && r_first < 0) r_first = r_cyc;
   endtask

   task automatic start_game();
      gameState = 1'b0;
      repeat (3) step();
      gameState = 1'b1;
      repeat (3) step();
      model_start();
   endtask

   // One full round: a junk press while closed, window open, optional press
   // (plus a repeat press), window close. kv == 0 means no press.
   task automatic run_round(input logic [3:0] tgt, input logic [3:0] kv,
                            input bit coincide, input string name);
      int exp_h;
      int exp_m;
      int t0;
      logic [3:0] junk;
      exp_h = 0;
      exp_m = 0;
      if (!m_over) begin
         if (kv == 4'd0)      exp_m = 1;
         else if (kv == tgt)  exp_h = 1;
         else                 exp_m = 1;
      end
      clear_obs();
      junk = 4'($urandom_range(1, 15));
      keys = junk;
      repeat (3) step();
      keys = 4'd0;
      repeat (8) step();
      target = tgt;
      window = 1'b1;
      repeat (6) step();
      if (kv != 4'd0) begin
         keys = kv;
         if (coincide) window = 1'b0;
         t0 = r_cyc;
         repeat (3) step();
         keys = 4'd0;
         repeat (3) step();
         keys = kv;
         repeat (3) step();
         keys = 4'd0;
         repeat (3) step();
         window = 1'b0;
         repeat (8) step();
      end else begin
         window = 1'b0;
         t0 = r_cyc;
         repeat (8) step();
      end
      if (exp_h != 0) model_hit();
      else if (exp_m != 0) model_miss();

      n_cmp++;
      if (r_hits !== exp_h || r_misses !== exp_m || r_both !== 0) begin
         n_bad++;
         $display("FAIL %s verdict: hit=%0d miss=%0d both=%0d, expected hit=%0d miss=%0d both=0",
                  name, r_hits, r_misses, r_both, exp_h, exp_m);
      end
      if (exp_h + exp_m > 0) begin
         n_cmp++;
         if (r_first !== t0 + 4) begin
            n_bad++;
            $display("FAIL %s latency: pulse at cycle %0d, expected %0d", name, r_first, t0 + 4);
         end
      end
      n_cmp++;
      if ({score, lives, roundTime, gameOver} !==
          {m_score[7:0], m_lives[1:0], m_rt[3:0], m_over}) begin
         n_bad++;
         $display("FAIL %s counters: score=%0d lives=%0d rt=%0d over=%0d, expected %0d %0d %0d %0d",
                  name, score, lives, roundTime, gameOver, m_score, m_lives, m_rt, m_over);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b1;
      gameState = 1'b0;
      window    = 1'b0;
      keys      = 4'd0;
      target    = 4'd0;
      #3 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({hit, miss, score, lives, roundTime, gameOver} !== {1'b0, 1'b0, 8'd0, 2'd3, 4'd12, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_values: hit=%0d miss=%0d score=%0d lives=%0d rt=%0d over=%0d, expected 0 0 0 3 12 0",
                  hit, miss, score, lives, roundTime, gameOver);
      end
      clear_obs();
      repeat (4) step();
      rst_n = 1'b1;
      repeat (2) step();
      n_cmp++;
      if (r_hits + r_misses !== 0 || lives !== 2'd3 || roundTime !== 4'd12) begin
         n_bad++;
         $display("FAIL reset_hold: pulses=%0d lives=%0d rt=%0d, expected 0 3 12",
                  r_hits + r_misses, lives, roundTime);
      end
   endtask

   task automatic test_correct_press();
      start_game();
      run_round(4'b0001, 4'b0001, 1'b0, "correct_press");
   endtask

   task automatic test_timeout();
      run_round(onehot($urandom_range(0, 3)), 4'd0, 1'b0, "timeout");
   endtask

   task automatic test_wrong_press();
      run_round(4'b0100, 4'b0110, 1'b0, "wrong_press");
   endtask

   task automatic test_game_over();
      start_game();
      for (int i = 0; i < 3; i++) run_round(onehot($urandom_range(0, 3)), 4'd0, 1'b0, "over_timeout");
      n_cmp++;
      if (lives !== 2'd0 || gameOver !== 1'b1) begin
         n_bad++;
         $display("FAIL game_over_flag: lives=%0d over=%0d, expected 0 1", lives, gameOver);
      end
      run_round(4'b0010, 4'd0, 1'b0, "over_ignored_timeout");
      run_round(4'b1000, 4'b1000, 1'b0, "over_ignored_press");
      start_game();
      n_cmp++;
      if ({score, lives, roundTime, gameOver} !== {8'd0, 2'd3, 4'd12, 1'b0}) begin
         n_bad++;
         $display("FAIL restart: score=%0d lives=%0d rt=%0d over=%0d, expected 0 3 12 0",
                  score, lives, roundTime, gameOver);
      end
   endtask

   task automatic test_difficulty();
      logic [3:0] t;
      start_game();
      for (int i = 1; i <= 260; i++) begin
         t = onehot($urandom_range(0, 3));
         run_round(t, t, 1'b0, "diff_hit");
         if (i == 7 || i == 8 || i == 64) begin
            n_cmp++;
            if (roundTime !== ((i == 7) ? 4'd12 : (i == 8) ? 4'd11 : 4'd4)) begin
               n_bad++;
               $display("FAIL diff_rt_after_%0d: rt=%0d", i, roundTime);
            end
         end
      end
      n_cmp++;
      if (score !== 8'd255 || roundTime !== 4'd4) begin
         n_bad++;
         $display("FAIL diff_saturate: score=%0d rt=%0d, expected 255 4", score, roundTime);
      end
   endtask

   task automatic test_coincide();
      logic [3:0] t;
      start_game();
      t = onehot($urandom_range(0, 3));
      run_round(t, t, 1'b1, "coincide_hit");
   endtask

   task automatic test_random();
      logic [3:0] t;
      logic [3:0] k;
      int kind;
      start_game();
      for (int i = 0; i < 40; i++) begin
         if (m_over) start_game();
         t = onehot($urandom_range(0, 3));
         kind = $urandom_range(0, 3);
         case (kind)
            0: k = t;
            1: begin
               k = 4'($urandom_range(1, 15));
               if (k == t) k = k ^ 4'b1001;
            end
            2: k = 4'd0;
            default: k = ($urandom_range(0, 1) == 0) ? t : ~t;
         endcase
         run_round(t, k, (kind == 3), "random_round");
      end
   endtask

   task automatic test_abort();
      start_game();
      run_round(4'b0010, 4'b0010, 1'b0, "abort_pre_hit");
      clear_obs();
      target = 4'b0010;
      window = 1'b1;
      repeat (6) step();
      gameState = 1'b0;
      repeat (2) step();
      keys = 4'b0010;
      repeat (3) step();
      keys = 4'd0;
      window = 1'b0;
      repeat (8) step();
      n_cmp++;
      if (r_hits + r_misses !== 0 ||
          {score, lives, roundTime} !== {m_score[7:0], m_lives[1:0], m_rt[3:0]}) begin
         n_bad++;
         $display("FAIL abort: pulses=%0d score=%0d lives=%0d rt=%0d, expected 0 %0d %0d %0d",
                  r_hits + r_misses, score, lives, roundTime, m_score, m_lives, m_rt);
      end
   endtask

   task automatic test_reset_mid();
      start_game();
      run_round(4'b0001, 4'b0001, 1'b0, "mid_pre_hit");
      run_round(4'b0100, 4'b0100, 1'b0, "mid_pre_hit");
      run_round(4'b1000, 4'd0, 1'b0, "mid_pre_timeout");
      clear_obs();
      target = 4'b0001;
      window = 1'b1;
      repeat (6) step();
      keys = 4'b0001;
      repeat (2) step();
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({hit, miss, score, lives, roundTime, gameOver} !== {1'b0, 1'b0, 8'd0, 2'd3, 4'd12, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_mid: hit=%0d miss=%0d score=%0d lives=%0d rt=%0d over=%0d, expected 0 0 0 3 12 0",
                  hit, miss, score, lives, roundTime, gameOver);
      end
      keys      = 4'd0;
      window    = 1'b0;
      gameState = 1'b0;
      clear_obs();
      repeat (6) step();
      rst_n = 1'b1;
      repeat (6) step();
      n_cmp++;
      if (r_hits + r_misses !== 0) begin
         n_bad++;
         $display("FAIL reset_mid_pulse: pulses=%0d, expected 0", r_hits + r_misses);
      end
      start_game();
      run_round(4'b0010, 4'b0010, 1'b0, "post_reset_hit");
   endtask

   initial begin
      test_reset();
      test_correct_press();
      test_timeout();
      test_wrong_press();
      test_game_over();
      test_coincide();
      test_abort();
      test_random();
      test_difficulty();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/round_judge.md
# round_judge

Round judging stage that consumes the round-window signal produced by the `timing` stage, together with the debounced finger keys, and decides per round whether the player hit the target key. It keeps the score and lives, and flags game over. It also drives the `roundTime` value back into `timing`, so the round window shrinks as the player improves. It sits between the key/target inputs, the timing stage and the display logic.

## Interface
- `LIVES_INIT`, default 3: lives loaded at reset and at game start.
- `RT_START`, default 12: `roundTime` loaded at reset and at game start.
- `RT_MIN`, default 4: floor for `roundTime`.
- `HITS_PER_LEVEL`, default 8: hits between successive `roundTime` decrements (power of two).
- `clk` in 1: system clock; every register here uses it.
- `rst_n` in 1: asynchronous, active-low reset.
- `gameState` in 1: game running (level).
- `window` in 1: round window from `timing` (`cout`); high means the round is open.
- `target` in 4: one-hot expected key for the current round; sampled when the window opens.
- `keys` in 4: debounced key levels, active-high, asynchronous to `clk`.
- `roundTime` out 4: period selector fed to `timing`.
- `hit` out 1: one-cycle pulse on a correct press.
- `miss` out 1: one-cycle pulse on a wrong press or an expired window.
- `score` out 8: hit count, saturating at 255.
- `lives` out 2: remaining lives.
- `gameOver` out 1: level; set when `lives` reaches 0.

## Operation
- `window` and `keys` pass through a two-flop synchronizer. A key edge is `sync & ~prev`.
- States: IDLE, WAIT_OPEN, ARMED, JUDGED, OVER.
- IDLE, on `gameState` 0→1:
  - `score` 0, `lives` LIVES_INIT, `roundTime` RT_START, `gameOver` 0.
  - Next state is WAIT_OPEN.
- WAIT_OPEN, on synchronized `window` rising: latch `target` into `tgt_q`, then go to ARMED.
- ARMED, first cycle with a nonzero edge vector:
  - Edge vector == `tgt_q`: `hit` pulse, `score`+1 (saturating).
  - Any other vector, including multi-key or extra keys: `miss` pulse, `lives`−1.
  - Next state is JUDGED.
- ARMED, synchronized `window` falls with no edge: `miss`, `lives`−1, then WAIT_OPEN.
- JUDGED: further presses are ignored. On window fall, go to WAIT_OPEN.
- Presses while in WAIT_OPEN (window closed) are ignored and never judged.
- Any miss that makes `lives` 0 sets `gameOver` and moves to OVER. OVER stays until `gameState` is 0, then goes to IDLE.
- Difficulty:
  - On a hit where the new `score` mod HITS_PER_LEVEL == 0 and `roundTime` > RT_MIN, `roundTime` decrements by 1.
  - `roundTime` never goes below RT_MIN and never changes at 255 saturation.
- `gameState` 0 in any state other than OVER: abort to IDLE with no miss. `score`, `lives` and `roundTime` hold their values until the next start.
- `hit` and `miss` are never high in the same cycle.

## Timing
- Reset values:
  - state IDLE, `score` 0, `lives` LIVES_INIT, `roundTime` RT_START.
  - `hit` 0, `miss` 0, `gameOver` 0, synchronizer flops 0.
- Key-to-verdict latency: a key level first sampled at clock edge k gives an edge at k+2. `hit`/`miss` are registered and visible after edge k+3.
- Window-close-to-timeout `miss`: the same 3-cycle latency from the first sampling edge of `window` low.
- A key edge and a synchronized window fall in the same cycle: the press is judged; no timeout miss.
- `score`, `lives`, `roundTime` and `gameOver` update in the same cycle as the `hit`/`miss` pulse.
- A reset assertion mid-round takes effect immediately (asynchronous); all outputs return to reset values with no pulse.

## Structure
- `round_judge_pkg`:
  - state enum.
  - key width (4), score width (8), lives width (2).
  - defaults for LIVES_INIT, RT_START, RT_MIN, HITS_PER_LEVEL.
- Sub-module `key_sync_edge`, parameterized width: two-flop synchronizer plus rising-edge detect. Instantiated once with 5 bits (`window` and `keys`). Window fall is derived from the same flops.
- The FSM, score, lives and difficulty logic live in `round_judge`.

## Test plan
- Correct press: reset, start game, open window with `target`=0001, press `keys`=0001 → one `hit` 3 cycles later, `score`=1, `lives`=3. A second press in the same window causes no pulse.
- Timeout: open window, no press, close window → one `miss`, `lives` 3→2, state WAIT_OPEN.
- Wrong press: `target`=0100, press 0110 → `miss`, `lives`−1. A press in the closed window beforehand produces no pulse.
- Game over: three timeouts → third `miss` with `lives`=0 and `gameOver`=1. Further windows are ignored. Drop `gameState` → IDLE; restart → `lives`=3, `score`=0, `gameOver`=0.
- Difficulty:
  - 8 consecutive hits → `roundTime` 12→11 on the 8th hit.
  - 64 hits → `roundTime` stays at 4.
  - Force 260 hits → `score` saturates at 255.
- Edge cases:
  - Press coinciding with the synchronized window fall → `hit`, no `miss`.
  - Reset asserted mid-ARMED → all outputs return to reset values immediately.
